// File: rtl/pulse_stretch_decoder.sv
// pulse_stretch_decoder
//   Receive end of the pulse-stretch link. Each stretched pulse (nominally
//   STRETCH_LEN cycles high) is measured. A pulse whose width is in tolerance
//   becomes a single-cycle o_out_pulse event. Runt, over-long and stuck-high
//   pulses raise a single-cycle o_width_err instead. Saturating good/bad
//   counters are kept for status.
//
//   Optional feature: define PULSE_DEC_SYNC_EN to pass i_in_pulse through a
//   2-flop synchronizer before the FSM. This adds 2 cycles of latency and
//   leaves the measured widths unchanged.
//
// Ports
//   i_clk        in   1      single clock, rising edge
//   i_rst        in   1      synchronous, active-high reset
//   i_in_pulse   in   1      stretched pulse from the stretcher
//   o_out_pulse  out  1      1-cycle recovered event
//   o_width_err  out  1      1-cycle flag: bad width or stuck-high
//   o_width_val  out  CNT_W  width of last completed/aborted pulse (held)
//   o_ok_cnt     out  16     accepted pulses, saturating
//   o_err_cnt    out  16     width_err flags, saturating
module pulse_stretch_decoder #(
  parameter int STRETCH_LEN = 5,
  parameter int TOL         = 0,
  parameter int MAX_W       = 16,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_pulse,
  output logic             o_out_pulse,
  output logic             o_width_err,
  output logic [CNT_W-1:0] o_width_val,
  output logic [15:0]      o_ok_cnt,
  output logic [15:0]      o_err_cnt
);

  // A zero-width pulse cannot be observed, so the lower bound never drops below 1.
  localparam int               LO_I  = (STRETCH_LEN - TOL < 1) ? 1 : STRETCH_LEN - TOL;
  localparam logic [CNT_W-1:0] LO_W  = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] HI_W  = CNT_W'(STRETCH_LEN + TOL);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;

  logic             w_in_s;
  logic             w_in_vld;

  state_t           r_state,      w_state_next;
  logic [CNT_W-1:0] r_cnt,        w_cnt_next;
  logic             r_armed,      w_armed_next;
  logic             r_out_pulse,  w_out_next;
  logic             r_width_err,  w_err_next;
  logic [CNT_W-1:0] r_width_val,  w_wval_next;
  logic [15:0]      r_ok_cnt,     w_ok_next;
  logic [15:0]      r_err_cnt,    w_errc_next;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef PULSE_DEC_SYNC_EN
  logic [1:0] r_sync;
  logic [1:0] r_sync_vld;

  // r_sync_vld tracks when the synchronizer holds real samples again after
  // reset. This keeps the FSM from arming on the flushed zeros.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync     <= 2'b00;
      r_sync_vld <= 2'b00;
    end else begin
      r_sync     <= {r_sync[0], i_in_pulse};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  assign w_in_s   = r_sync[1];
  assign w_in_vld = r_sync_vld[1];
`else
  assign w_in_s   = i_in_pulse;
  assign w_in_vld = 1'b1;
`endif

  // r_armed is cleared by reset and set by the first genuine low sample. A
  // pulse already high when reset releases is therefore never measured.
  assign w_armed_next = r_armed | (w_in_vld & ~w_in_s);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_out_next   = 1'b0;
    w_err_next   = 1'b0;
    w_wval_next  = r_width_val;
    w_ok_next    = r_ok_cnt;
    w_errc_next  = r_err_cnt;
    case (r_state)
      IDLE: begin
        if (w_in_s && r_armed) begin
          w_state_next = MEASURE;
          w_cnt_next   = ONE_C;
        end
      end
      MEASURE: begin
        if (w_in_s) begin
          if (r_cnt == MAX_C) begin
            w_err_next   = 1'b1;
            w_wval_next  = MAX_C;
            w_errc_next  = sat_inc(r_err_cnt);
            w_state_next = STUCK;
          end else begin
            w_cnt_next = r_cnt + ONE_C;
          end
        end else begin
          w_wval_next = r_cnt;
          if (r_cnt >= LO_W && r_cnt <= HI_W) begin
            w_out_next = 1'b1;
            w_ok_next  = sat_inc(r_ok_cnt);
          end else begin
            w_err_next  = 1'b1;
            w_errc_next = sat_inc(r_err_cnt);
          end
          w_state_next = IDLE;
        end
      end
      STUCK: begin
        // The stuck condition was already flagged, so releasing it is silent.
        if (!w_in_s) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_armed     <= 1'b0;
      r_out_pulse <= 1'b0;
      r_width_err <= 1'b0;
      r_width_val <= '0;
      r_ok_cnt    <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_armed     <= w_armed_next;
      r_out_pulse <= w_out_next;
      r_width_err <= w_err_next;
      r_width_val <= w_wval_next;
      r_ok_cnt    <= w_ok_next;
      r_err_cnt   <= w_errc_next;
    end
  end

  assign o_out_pulse = r_out_pulse;
  assign o_width_err = r_width_err;
  assign o_width_val = r_width_val;
  assign o_ok_cnt    = r_ok_cnt;
  assign o_err_cnt   = r_err_cnt;

endmodule
